// File: rtl/pcc_sched_pkg.sv
// Shared definitions for the pcc sequential scheduler: FSM states, the default
// slice widths of the pcc_2_6 compare family, and the vote-count width helper.
package pcc_sched_pkg;

    // Scheduler states: wait for a sample, walk the neurons, hold the result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_t;

    // Default widths of the shared pcc_2_6 unit (2 positive, 6 negative inputs).
    localparam int DEF_POS_W = 2;
    localparam int DEF_NEG_W = 6;

    // Width needed to count 0..n votes without wrapping.
    function automatic int score_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pcc_seq_sched.sv
// Time-multiplexes one external pos/neg popcount-compare unit across NEURONS
// binary neurons. A sample is latched on the input handshake, each neuron's
// slice pair is presented to the shared pcc for one cycle, and the 1-bit
// decisions are gathered into out_bits with a running vote count in out_score.
//
// Handshake rules (both ports): a transfer happens on a rising clk edge where
// valid && ready are both high. valid, once raised by the producer, is not
// required to stay up; this block only ever looks at the edge where both are
// high. out_valid stays high, with out_bits/out_score stable, until accepted.
module pcc_seq_sched
    import pcc_sched_pkg::*;
#(
    parameter int NEURONS = 4,
    parameter int POS_W   = DEF_POS_W,
    parameter int NEG_W   = DEF_NEG_W,
    parameter int SCORE_W = score_width(NEURONS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NEURONS*POS_W-1:0] in_pos,
    input  logic [NEURONS*NEG_W-1:0] in_neg,
    output logic [POS_W-1:0]         pcc_pos,
    output logic [NEG_W-1:0]         pcc_neg,
    input  logic                     pcc_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NEURONS-1:0]       out_bits,
    output logic [SCORE_W-1:0]       out_score,
    output logic                     busy
);

    // Neuron index only needs to reach NEURONS-1.
    localparam int               IDX_W    = (NEURONS > 1) ? $clog2(NEURONS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURONS - 1);

    sched_state_t state_q;
    sched_state_t state_d;

    logic [IDX_W-1:0]         idx_q;
    logic [NEURONS*POS_W-1:0] pos_q;
    logic [NEURONS*NEG_W-1:0] neg_q;
    logic [NEURONS-1:0]       res_q;
    logic [SCORE_W-1:0]       score_q;

    // Control strobes produced by the FSM and consumed by the datapath.
    logic load;     // accept a new sample this edge
    logic step;     // record the current neuron's decision this edge
    logic last;     // current neuron is the final one

    assign last = (idx_q == LAST_IDX);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and handshake/control decode.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                // A new sample may only enter as the current result leaves,
                // which gives zero-bubble back-to-back operation.
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load    = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sample latch: the input bus is only sampled on the accept edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_q <= '0;
            neg_q <= '0;
        end else if (load) begin
            pos_q <= in_pos;
            neg_q <= in_neg;
        end
    end

    // Neuron index: restarts on load, advances each RUN cycle, wraps after the last.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (load) begin
            idx_q <= '0;
        end else if (step) begin
            idx_q <= last ? '0 : idx_q + 1'b1;
        end
    end

    // Result and vote accumulators: cleared on load, one decision per RUN cycle.
    // The count cannot exceed NEURONS, so SCORE_W bits never wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q   <= '0;
            score_q <= '0;
        end else if (load) begin
            res_q   <= '0;
            score_q <= '0;
        end else if (step) begin
            res_q[idx_q] <= pcc_out;
            score_q      <= score_q + SCORE_W'(pcc_out);
        end
    end

    // Slice steering to the shared pcc; quiet (all zero) outside RUN.
    always_comb begin
        pcc_pos = '0;
        pcc_neg = '0;
        if (state_q == ST_RUN) begin
            pcc_pos = pos_q[idx_q*POS_W +: POS_W];
            pcc_neg = neg_q[idx_q*NEG_W +: NEG_W];
        end
    end

    assign out_bits  = res_q;
    assign out_score = score_q;

endmodule

// File: tb/tb_pcc_seq_sched.sv
// Bench for pcc_seq_sched: a behavioural pcc drives pcc_out, a reference
// model derives each sample's decisions directly from popcounts of its slices.
module tb_pcc_seq_sched;

    localparam int N  = 4;
    localparam int PW = 2;
    localparam int NW = 6;
    localparam int SW = 3;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [N*PW-1:0] in_pos;
    logic [N*NW-1:0] in_neg;
    logic [PW-1:0]   pcc_pos;
    logic [NW-1:0]   pcc_neg;
    logic            pcc_out;
    logic            out_valid;
    logic            out_ready;
    logic [N-1:0]    out_bits;
    logic [SW-1:0]   out_score;
    logic            busy;

    int checks;
    int errors;

    logic [N-1:0] exp_q[$];

    pcc_seq_sched #(.NEURONS(N), .POS_W(PW), .NEG_W(NW), .SCORE_W(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pos(in_pos), .in_neg(in_neg),
        .pcc_pos(pcc_pos), .pcc_neg(pcc_neg), .pcc_out(pcc_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bits(out_bits), .out_score(out_score),
        .busy(busy)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shared pcc.
    assign pcc_out = ($countones(pcc_pos) >= $countones(pcc_neg));

    // Reference model: decision of every neuron from its slice popcounts.
    function automatic logic [N-1:0] model_bits(input logic [N*PW-1:0] p, input logic [N*NW-1:0] n);
        logic [N-1:0] r;
        for (int k = 0; k < N; k++)
            r[k] = ($countones(p[k*PW +: PW]) >= $countones(n[k*NW +: NW]));
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a sample and wait (bounded) for the accept edge; returns just after it.
    task automatic accept(input logic [N*PW-1:0] p, input logic [N*NW-1:0] n);
        int waited;
        in_pos   = p;
        in_neg   = n;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
        end
        exp_q.push_back(model_bits(p, n));
        tick();
        in_valid = 1'b0;
    endtask

    // Walk the RUN phase just after the accept edge and check the result in DONE.
    task automatic check_run(input logic [N*PW-1:0] p, input logic [N*NW-1:0] n, input bit scramble);
        logic [N-1:0] exp_bits;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (pcc_pos !== p[k*PW +: PW] || pcc_neg !== n[k*NW +: NW]) begin
                errors++;
                $display("FAIL slice_%0d: pcc_pos=%0h pcc_neg=%0h, required %0h %0h",
                         k, pcc_pos, pcc_neg, p[k*PW +: PW], n[k*NW +: NW]);
            end
            checks++;
            if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL run_flags_%0d: busy=%0b out_valid=%0b in_ready=%0b, required 1 0 0",
                         k, busy, out_valid, in_ready);
            end
            if (scramble) begin
                in_pos   = N*PW'($urandom);
                in_neg   = N*NW'($urandom);
                in_valid = 1'($urandom_range(0, 1));
            end
            tick();
        end
        in_valid = 1'b0;
        exp_bits = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_flags: out_valid=%0b busy=%0b, required 1 0", out_valid, busy);
        end
        checks++;
        if (out_bits !== exp_bits || out_score !== SW'($countones(exp_bits))) begin
            errors++;
            $display("FAIL result: out_bits=%b out_score=%0d, required %b %0d",
                     out_bits, out_score, exp_bits, $countones(exp_bits));
        end
        checks++;
        if (pcc_pos !== '0 || pcc_neg !== '0 || in_ready !== out_ready) begin
            errors++;
            $display("FAIL done_outputs: pcc_pos=%0h pcc_neg=%0h in_ready=%0b, required 0 0 %0b",
                     pcc_pos, pcc_neg, in_ready, out_ready);
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release: out_valid=%0b in_ready=%0b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_pos    = '1;
        in_neg    = '0;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_bits !== '0 ||
            out_score !== '0 || pcc_pos !== '0 || pcc_neg !== '0) begin
            errors++;
            $display("FAIL reset: rdy=%0b ov=%0b busy=%0b bits=%b score=%0d pp=%0h pn=%0h, required 1 0 0 0 0 0 0",
                     in_ready, out_valid, busy, out_bits, out_score, pcc_pos, pcc_neg);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [N*PW-1:0] p;
        logic [N*NW-1:0] n;
        p = {2'b01, 2'b01, 2'b00, 2'b11};
        n = {6'b110000, 6'b000000, 6'b000001, 6'b000001};
        accept(p, n);
        check_run(p, n, 1'b0);
        checks++;
        if (out_bits !== 4'b0101 || out_score !== 3'd2) begin
            errors++;
            $display("FAIL single_fixed: out_bits=%b out_score=%0d, required 0101 2", out_bits, out_score);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        logic [N*PW-1:0] p;
        logic [N*NW-1:0] n;
        logic [N-1:0]    b0;
        logic [SW-1:0]   s0;
        p = N*PW'($urandom);
        n = N*NW'($urandom);
        accept(p, n);
        check_run(p, n, 1'b0);
        b0 = out_bits;
        s0 = out_score;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_bits !== b0 || out_score !== s0) begin
                errors++;
                $display("FAIL backpressure_%0d: ov=%0b rdy=%0b bits=%b score=%0d, required 1 0 %b %0d",
                         c, out_valid, in_ready, out_bits, out_score, b0, s0);
            end
        end
        in_valid = 1'b0;
        release_result();
    endtask

    task automatic test_back_to_back();
        logic [N*PW-1:0] p;
        logic [N*NW-1:0] n;
        p = N*PW'($urandom);
        n = N*NW'($urandom);
        accept(p, n);
        check_run(p, n, 1'b0);
        out_ready = 1'b1;
        accept('1, '0);
        out_ready = 1'b0;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_bubble: busy=%0b out_valid=%0b, required 1 0", busy, out_valid);
        end
        check_run('1, '0, 1'b0);
        checks++;
        if (out_bits !== 4'hF || out_score !== 3'd4) begin
            errors++;
            $display("FAIL b2b_all_ones: out_bits=%h out_score=%0d, required f 4", out_bits, out_score);
        end
        release_result();
    endtask

    task automatic test_reset_mid_run();
        logic [N*PW-1:0] p;
        logic [N*NW-1:0] n;
        p = '1;
        n = '0;
        accept(p, n);
        tick();
        tick();
        checks++;
        if (pcc_pos !== p[2*PW +: PW] || busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_idx2: pcc_pos=%0h busy=%0b, required %0h 1", pcc_pos, busy, p[2*PW +: PW]);
        end
        void'(exp_q.pop_back());
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_bits !== '0 ||
            out_score !== '0 || pcc_pos !== '0 || pcc_neg !== '0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%0b ov=%0b rdy=%0b bits=%b score=%0d, required 0 0 1 0 0",
                     busy, out_valid, in_ready, out_bits, out_score);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL midrun_no_valid_%0d: out_valid=%0b, required 0", c, out_valid);
            end
        end
        p = {2'b00, 2'b01, 2'b00, 2'b10};
        n = {6'b000001, 6'b000011, 6'b000000, 6'b111111};
        accept(p, n);
        check_run(p, n, 1'b0);
        release_result();
    endtask

    task automatic test_random();
        logic [N*PW-1:0] p;
        logic [N*NW-1:0] n;
        for (int t = 0; t < 30; t++) begin
            p = N*PW'($urandom);
            n = N*NW'($urandom);
            if ($urandom_range(0, 3) == 0) n = n & N*NW'(24'h030303);
            accept(p, n);
            check_run(p, n, 1'($urandom_range(0, 1)));
            for (int w = $urandom_range(0, 3); w > 0; w--) tick();
            release_result();
            for (int w = $urandom_range(0, 2); w > 0; w--) tick();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
